frame_buffer: RTL and testbench
===============================

FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 Parameter COLS, default 32: panel columns; width of each row-data output; only 32 supported.
REQ-002 Parameter ROW_PAIRS, default 16: scanned row pairs (top row y, bottom row y+16).
REQ-003 CLK_I  in  1  single clock; all state on rising edge.
REQ-004 RST_N_I  in  1  reset, asynchronous, active-low.
REQ-005 PIX_VALID_I  in  1  pixel write request.
REQ-006 PIX_READY_O  out  1  write side can accept; write occurs when VALID and READY are both high at an edge.
REQ-007 PIX_X_I  in  5  column 0..31.
REQ-008 PIX_Y_I  in  5  row 0..31; bit 4 = 0 top bank, 1 bottom bank; bits 3:0 = row pair.
REQ-009 PIX_RGB_I  in  3  {R,G,B} 1-bit colour.
REQ-010 SWAP_REQ_I  in  1  one-cycle pulse: promote write bank to display bank at next frame boundary.
REQ-011 SWAP_DONE_O  out  1  one-cycle pulse when the swap takes effect.
REQ-012 ROW_REQ_I  in  1  one-cycle pulse from panel driver requesting a row pair.
REQ-013 ROW_ADDR_I  in  4  requested row pair, sampled with ROW_REQ_I.
REQ-014 ROW_VALID_O  out  1  R0_O..B1_O hold a complete row pair.
REQ-015 ROW_ACK_I  in  1  driver has latched the row data.
REQ-016 R0_O, G0_O, B0_O, R1_O, G1_O, B1_O  out  32 each  row data; bit c = column c (bit 0 shifted first).

Function
REQ-017 Two banks, each 512 entries x 3 bits for top and 512 x 3 bits for bottom, indexed {row_pair, column}; RAM contents not reset.
REQ-018 Display bank register disp selects the read bank; writes always go to bank ~disp.
REQ-019 Pixel write: single-cycle, writes PIX_RGB_I to bank ~disp, half PIX_Y_I[4], entry {PIX_Y_I[3:0], PIX_X_I}; other half untouched.
REQ-020 PIX_READY_O = 1 except while swap_pending = 1 (0 from the edge sampling SWAP_REQ_I until the edge applying the swap).
REQ-021 Read FSM states: IDLE, FETCH, HOLD.
REQ-022 IDLE: ROW_REQ_I=1 -> latch ROW_ADDR_I, clear column counter, go FETCH.
REQ-023 FETCH: read columns 0..31 of the latched row pair from bank disp, assemble into R0_O..B1_O; go HOLD.
REQ-024 Latency: ROW_VALID_O rises exactly 34 rising edges after the edge sampling ROW_REQ_I, constant for every request.
REQ-025 HOLD: ROW_VALID_O = 1, outputs stable; ROW_ACK_I=1 -> ROW_VALID_O = 0 next cycle, go IDLE; outputs keep last value after leaving HOLD.
REQ-026 ROW_REQ_I in FETCH or HOLD is ignored (no queueing); ROW_ACK_I outside HOLD is ignored.
REQ-027 Swap applied only at frame boundary: at the edge where FSM is IDLE, ROW_REQ_I=1, ROW_ADDR_I=0 and swap_pending=1; disp toggles, swap_pending clears, SWAP_DONE_O pulses next cycle, and that fetch reads the new disp bank.
REQ-028 SWAP_REQ_I while swap_pending already 1 has no additional effect (one toggle only).
REQ-029 SWAP_REQ_I and accepted pixel write in same edge: the write completes into the old write bank before the swap.
REQ-030 ROW_ADDR_I > ROW_PAIRS-1 is unreachable for 4 bits at default; no range check required.

Reset
REQ-031 Asserting RST_N_I low, at any time including mid-FETCH, immediately forces: FSM IDLE, disp = 0, swap_pending = 0, PIX_READY_O = 1, ROW_VALID_O = 0, SWAP_DONE_O = 0, R0_O..B1_O = 0, column counter = 0.
REQ-032 First ROW_REQ_I is accepted on the first rising edge after RST_N_I deasserts.

Verification
REQ-033 Write (x=5,y=3,RGB=3'b101) and (x=5,y=19,RGB=3'b010), SWAP_REQ_I, ROW_REQ addr 0, ack, ROW_REQ addr 3 -> after 34 cycles R0_O[5]=1,G0_O[5]=0,B0_O[5]=1,R1_O[5]=0,G1_O[5]=1,B1_O[5]=0, all other bits 0 (if banks were prefilled 0).
REQ-034 SWAP_REQ_I then ROW_REQ addr 7 -> no swap, PIX_READY_O stays 0; next ROW_REQ addr 0 -> SWAP_DONE_O pulse, PIX_READY_O back to 1.
REQ-035 ROW_REQ_I pulsed mid-FETCH and during HOLD -> ignored; exactly one ROW_VALID_O assertion, latency 34.
REQ-036 Hold ROW_ACK_I low 100 cycles -> ROW_VALID_O and data stable all 100 cycles; ack -> ROW_VALID_O low next cycle.
REQ-037 RST_N_I low at cycle 10 of FETCH -> ROW_VALID_O=0, outputs 0 asynchronously; new request after release completes normally in 34 cycles.
REQ-038 Two SWAP_REQ_I pulses before frame boundary -> single disp toggle, single SWAP_DONE_O pulse.

Source files
------------

// File: rtl/frame_buffer.sv
// frame_buffer: double-buffered 32x32 RGB (1 bit per colour) frame store
// for a 1/16-scan LED panel driver.
//
// Write side : PIX_VALID_I/PIX_READY_O handshake, PIX_X_I/PIX_Y_I/PIX_RGB_I.
//              Writes always land in the bank not being displayed.
// Swap       : SWAP_REQ_I arms a pending swap. The swap is applied at the next
//              frame boundary, which is a row-pair 0 request. SWAP_DONE_O
//              pulses for one cycle when the swap takes effect. Pixel writes
//              are held off while a swap is pending.
// Read side  : ROW_REQ_I/ROW_ADDR_I request one row pair. ROW_VALID_O goes
//              high 34 edges later with R0_O..B1_O (top row y, bottom row
//              y+16) stable until ROW_ACK_I.
// Reset      : RST_N_I, asynchronous, active-low. RAM contents are not reset.
module frame_buffer #(
  parameter int unsigned COLS      = 32,
  parameter int unsigned ROW_PAIRS = 16
) (
  input  logic            CLK_I,
  input  logic            RST_N_I,
  input  logic            PIX_VALID_I,
  output logic            PIX_READY_O,
  input  logic [4:0]      PIX_X_I,
  input  logic [4:0]      PIX_Y_I,
  input  logic [2:0]      PIX_RGB_I,
  input  logic            SWAP_REQ_I,
  output logic            SWAP_DONE_O,
  input  logic            ROW_REQ_I,
  input  logic [3:0]      ROW_ADDR_I,
  output logic            ROW_VALID_O,
  input  logic            ROW_ACK_I,
  output logic [COLS-1:0] R0_O,
  output logic [COLS-1:0] G0_O,
  output logic [COLS-1:0] B0_O,
  output logic [COLS-1:0] R1_O,
  output logic [COLS-1:0] G1_O,
  output logic [COLS-1:0] B1_O
);

  // Each half (top/bottom) stores both banks: address = {bank, row_pair, col}.
  localparam int unsigned DEPTH = 2 * ROW_PAIRS * COLS;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_e;

  state_e state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [5:0] col_q, col_d;
  logic       disp_q, disp_d;
  logic       pend_q, pend_d;
  logic       done_q, done_d;

  // Index 2 = red, 1 = green, 0 = blue, matching the {R,G,B} pixel layout.
  logic [2:0][COLS-1:0] acc_top_q, acc_top_d;
  logic [2:0][COLS-1:0] acc_bot_q, acc_bot_d;
  logic [2:0][COLS-1:0] out_top_q, out_top_d;
  logic [2:0][COLS-1:0] out_bot_q, out_bot_d;

  logic [2:0] mem_top [DEPTH];
  logic [2:0] mem_bot [DEPTH];
  logic [2:0] rd_top_q;
  logic [2:0] rd_bot_q;

  logic          wr_en;
  logic          wr_top;
  logic          wr_bot;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [4:0]    wr_bit;
  logic          swap_apply;

  // Write port: always the non-displayed bank. Read port: always the
  // displayed bank, so the two ports never touch the same location.
  always_comb begin
    wr_en   = PIX_VALID_I & ~pend_q;
    wr_top  = wr_en & ~PIX_Y_I[4];
    wr_bot  = wr_en &  PIX_Y_I[4];
    wr_addr = {~disp_q, PIX_Y_I[3:0], PIX_X_I};
    rd_addr = {disp_q, row_q, col_q[4:0]};
  end

  always_ff @(posedge CLK_I) begin
    if (wr_top) begin
      mem_top[wr_addr] <= PIX_RGB_I;
    end
    if (wr_bot) begin
      mem_bot[wr_addr] <= PIX_RGB_I;
    end
    rd_top_q <= mem_top[rd_addr];
    rd_bot_q <= mem_bot[rd_addr];
  end

  // Fetch timeline (edge 0 samples ROW_REQ_I, col_q = k after edge k):
  //   edges 1..32  : RAM registers column col_q
  //   edges 2..33  : previous column's read data lands in accumulator bit col_q-1
  //   edge 34      : accumulator copied to outputs, enter HOLD
  // Assembling into a separate accumulator keeps R0_O..B1_O at the previous
  // row's values for the whole fetch.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    disp_d    = disp_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    acc_top_d = acc_top_q;
    acc_bot_d = acc_bot_q;
    out_top_d = out_top_q;
    out_bot_d = out_bot_q;
    wr_bit    = col_q[4:0] - 5'd1;

    swap_apply = (state_q == IDLE) && ROW_REQ_I && (ROW_ADDR_I == '0) && pend_q;

    if (SWAP_REQ_I) begin
      pend_d = 1'b1;
    end
    if (swap_apply) begin
      disp_d = ~disp_q;
      pend_d = 1'b0;
      done_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ROW_REQ_I) begin
          row_d   = ROW_ADDR_I;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        col_d = col_q + 6'd1;
        if ((col_q != '0) && (col_q <= 6'd32)) begin
          for (int unsigned k = 0; k < 3; k++) begin
            acc_top_d[k][wr_bit] = rd_top_q[k];
            acc_bot_d[k][wr_bit] = rd_bot_q[k];
          end
        end
        if (col_q == 6'd33) begin
          out_top_d = acc_top_q;
          out_bot_d = acc_bot_q;
          col_d     = '0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (ROW_ACK_I) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      disp_q    <= 1'b0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_top_q <= '0;
      acc_bot_q <= '0;
      out_top_q <= '0;
      out_bot_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      acc_top_q <= acc_top_d;
      acc_bot_q <= acc_bot_d;
      out_top_q <= out_top_d;
      out_bot_q <= out_bot_d;
    end
  end

  assign PIX_READY_O = ~pend_q;
  assign SWAP_DONE_O = done_q;
  assign ROW_VALID_O = (state_q == HOLD);
  assign R0_O        = out_top_q[2];
  assign G0_O        = out_top_q[1];
  assign B0_O        = out_top_q[0];
  assign R1_O        = out_bot_q[2];
  assign G1_O        = out_bot_q[1];
  assign B1_O        = out_bot_q[0];

endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: directed bench for frame_buffer. A behavioural model of
// both banks, the display-bank register and the pending-swap flag predicts
// each row; the prediction is queued when the request is driven and popped
// when ROW_VALID_O rises.
module tb_frame_buffer;

  typedef struct packed {
    logic [31:0] r0, g0, b0, r1, g1, b1;
  } row_t;

  logic        CLK_I = 1'b0;
  logic        RST_N_I;
  logic        PIX_VALID_I;
  logic        PIX_READY_O;
  logic [4:0]  PIX_X_I;
  logic [4:0]  PIX_Y_I;
  logic [2:0]  PIX_RGB_I;
  logic        SWAP_REQ_I;
  logic        SWAP_DONE_O;
  logic        ROW_REQ_I;
  logic [3:0]  ROW_ADDR_I;
  logic        ROW_VALID_O;
  logic        ROW_ACK_I;
  logic [31:0] R0_O, G0_O, B0_O, R1_O, G1_O, B1_O;

  frame_buffer #(.COLS(32), .ROW_PAIRS(16)) dut (
    .CLK_I       (CLK_I),
    .RST_N_I     (RST_N_I),
    .PIX_VALID_I (PIX_VALID_I),
    .PIX_READY_O (PIX_READY_O),
    .PIX_X_I     (PIX_X_I),
    .PIX_Y_I     (PIX_Y_I),
    .PIX_RGB_I   (PIX_RGB_I),
    .SWAP_REQ_I  (SWAP_REQ_I),
    .SWAP_DONE_O (SWAP_DONE_O),
    .ROW_REQ_I   (ROW_REQ_I),
    .ROW_ADDR_I  (ROW_ADDR_I),
    .ROW_VALID_O (ROW_VALID_O),
    .ROW_ACK_I   (ROW_ACK_I),
    .R0_O        (R0_O),
    .G0_O        (G0_O),
    .B0_O        (B0_O),
    .R1_O        (R1_O),
    .G1_O        (G1_O),
    .B1_O        (B1_O)
  );

  always #5 CLK_I = ~CLK_I;

  int   vectors     = 0;
  int   miscompares = 0;
  row_t exp_q[$];

  logic [2:0] m_top [2][512];
  logic [2:0] m_bot [2][512];
  bit         m_disp = 1'b0;
  bit         m_pend = 1'b0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic row_t model_row(input int a);
    row_t r;
    for (int c = 0; c < 32; c++) begin
      r.r0[c] = m_top[m_disp][a*32+c][2];
      r.g0[c] = m_top[m_disp][a*32+c][1];
      r.b0[c] = m_top[m_disp][a*32+c][0];
      r.r1[c] = m_bot[m_disp][a*32+c][2];
      r.g1[c] = m_bot[m_disp][a*32+c][1];
      r.b1[c] = m_bot[m_disp][a*32+c][0];
    end
    return r;
  endfunction

  function automatic logic [191:0] dut_row();
    return {R0_O, G0_O, B0_O, R1_O, G1_O, B1_O};
  endfunction

  task automatic wr_pix(input int x, input int y, input logic [2:0] rgb, input bit swap);
    int b;
    @(negedge CLK_I);
    PIX_VALID_I = 1'b1;
    PIX_X_I     = x[4:0];
    PIX_Y_I     = y[4:0];
    PIX_RGB_I   = rgb;
    SWAP_REQ_I  = swap;
    #1 chk("pix_ready", {191'b0, PIX_READY_O}, {191'b0, !m_pend});
    if (!m_pend) begin
      b = m_disp ? 0 : 1;
      if (y >= 16) m_bot[b][(y%16)*32+x] = rgb;
      else         m_top[b][(y%16)*32+x] = rgb;
    end
    if (swap) m_pend = 1'b1;
    @(posedge CLK_I);
    #1;
    PIX_VALID_I = 1'b0;
    SWAP_REQ_I  = 1'b0;
  endtask

  task automatic swap_pulse();
    @(negedge CLK_I);
    SWAP_REQ_I = 1'b1;
    m_pend     = 1'b1;
    @(posedge CLK_I);
    #1;
    SWAP_REQ_I = 1'b0;
    chk("ready_after_swap_req", {191'b0, PIX_READY_O}, 192'd0);
  endtask

  // Drives the request edge; returns just after that edge.
  task automatic start_row(input int addr);
    bit swapped;
    @(negedge CLK_I);
    ROW_REQ_I  = 1'b1;
    ROW_ADDR_I = addr[3:0];
    swapped    = (addr == 0) && m_pend;
    if (swapped) begin
      m_disp = ~m_disp;
      m_pend = 1'b0;
    end
    exp_q.push_back(model_row(addr));
    @(posedge CLK_I);
    #1;
    ROW_REQ_I = 1'b0;
    chk("swap_done", {191'b0, SWAP_DONE_O}, {191'b0, swapped});
    chk("ready_after_req", {191'b0, PIX_READY_O}, {191'b0, !m_pend});
  endtask

  // Waits (bounded) for ROW_VALID_O, checks latency and data. A stray
  // row-pair-0 request is pulsed in fetch cycle `inject` when inject >= 0.
  task automatic wait_row(input int inject, output row_t e);
    int lat        = 0;
    bit extra_done = 1'b0;
    while (ROW_VALID_O !== 1'b1 && lat < 60) begin
      if (lat == inject) begin
        ROW_REQ_I  = 1'b1;
        ROW_ADDR_I = 4'd0;
      end
      @(posedge CLK_I);
      #1;
      ROW_REQ_I = 1'b0;
      lat++;
      if (SWAP_DONE_O !== 1'b0) extra_done = 1'b1;
    end
    chk("row_latency", lat, 34);
    chk("swap_done_single", {191'b0, extra_done}, 192'd0);
    e = exp_q.pop_front();
    chk("row_data", dut_row(), e);
  endtask

  task automatic ack_row(input bit req_in_hold);
    if (req_in_hold) begin
      @(negedge CLK_I);
      ROW_REQ_I  = 1'b1;
      ROW_ADDR_I = 4'd0;
      @(posedge CLK_I);
      #1;
      ROW_REQ_I = 1'b0;
      chk("valid_after_hold_req", {191'b0, ROW_VALID_O}, 192'd1);
      chk("no_swap_in_hold", {191'b0, SWAP_DONE_O}, 192'd0);
    end
    @(negedge CLK_I);
    ROW_ACK_I = 1'b1;
    @(posedge CLK_I);
    #1;
    ROW_ACK_I = 1'b0;
    chk("valid_after_ack", {191'b0, ROW_VALID_O}, 192'd0);
  endtask

  task automatic clear_bank();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        wr_pix(x, y, 3'b000, 1'b0);
  endtask

  initial begin
    row_t e;
    row_t hold_e;
    bit   bad;
    RST_N_I     = 1'b0;
    PIX_VALID_I = 1'b0;
    PIX_X_I     = '0;
    PIX_Y_I     = '0;
    PIX_RGB_I   = '0;
    SWAP_REQ_I  = 1'b0;
    ROW_REQ_I   = 1'b0;
    ROW_ADDR_I  = '0;
    ROW_ACK_I   = 1'b0;

    #23;
    chk("rst_valid", {191'b0, ROW_VALID_O}, 192'd0);
    chk("rst_ready", {191'b0, PIX_READY_O}, 192'd1);
    chk("rst_swap_done", {191'b0, SWAP_DONE_O}, 192'd0);
    chk("rst_data", dut_row(), 192'd0);
    #4 RST_N_I = 1'b1;

    // Fill bank 1 (write bank while disp = 0) with known content.
    clear_bank();
    wr_pix(5, 3, 3'b101, 1'b0);
    wr_pix(5, 19, 3'b010, 1'b0);
    for (int x = 0; x < 32; x++) begin
      wr_pix(x, 7, 3'($urandom_range(7)), 1'b0);
      wr_pix(x, 23, 3'($urandom_range(7)), 1'b0);
    end
    // Write and swap request on the same edge: write still lands in bank 1.
    wr_pix(9, 7, 3'b110, 1'b1);

    // Frame boundary: swap to bank 1.
    start_row(0);
    wait_row(-1, e);
    ack_row(1'b0);

    start_row(3);
    wait_row(-1, e);
    chk("r0_col5", {160'b0, R0_O}, 192'h20);
    chk("g0_col5", {160'b0, G0_O}, 192'h0);
    chk("b0_col5", {160'b0, B0_O}, 192'h20);
    chk("r1_col5", {160'b0, R1_O}, 192'h0);
    chk("g1_col5", {160'b0, G1_O}, 192'h20);
    chk("b1_col5", {160'b0, B1_O}, 192'h0);
    ack_row(1'b0);

    start_row(7);
    wait_row(-1, e);
    ack_row(1'b0);

    // Fill bank 0 (now the write bank) with a pattern on row pair 2.
    clear_bank();
    for (int x = 0; x < 32; x++) begin
      wr_pix(x, 2, 3'($urandom_range(7)), 1'b0);
      wr_pix(x, 18, 3'($urandom_range(7)), 1'b0);
    end

    // Swap pending across a non-boundary row; writes refused meanwhile.
    swap_pulse();
    start_row(7);
    wait_row(-1, e);
    ack_row(1'b0);
    wr_pix(1, 2, 3'b111, 1'b0);
    swap_pulse();
    start_row(0);
    wait_row(-1, e);
    ack_row(1'b0);
    start_row(2);
    wait_row(-1, e);
    ack_row(1'b0);

    // Stray requests mid-fetch and in hold, with a swap pending.
    swap_pulse();
    start_row(5);
    wait_row(10, e);
    ack_row(1'b1);
    bad = 1'b0;
    repeat (40) begin
      @(posedge CLK_I);
      #1;
      if (ROW_VALID_O !== 1'b0 || SWAP_DONE_O !== 1'b0 || PIX_READY_O !== 1'b0) bad = 1'b1;
    end
    chk("no_queued_request", {191'b0, bad}, 192'd0);
    start_row(0);
    wait_row(-1, e);
    ack_row(1'b0);

    // Long hold without ack.
    start_row(3);
    wait_row(-1, hold_e);
    bad = 1'b0;
    repeat (100) begin
      @(posedge CLK_I);
      #1;
      if (ROW_VALID_O !== 1'b1 || dut_row() !== hold_e) bad = 1'b1;
    end
    chk("hold_stable_100", {191'b0, bad}, 192'd0);
    ack_row(1'b0);

    // Asynchronous reset in the middle of a fetch.
    swap_pulse();
    start_row(6);
    repeat (10) @(posedge CLK_I);
    #3 RST_N_I = 1'b0;
    #1;
    e = exp_q.pop_front();
    m_disp = 1'b0;
    m_pend = 1'b0;
    chk("midfetch_rst_valid", {191'b0, ROW_VALID_O}, 192'd0);
    chk("midfetch_rst_data", dut_row(), 192'd0);
    chk("midfetch_rst_ready", {191'b0, PIX_READY_O}, 192'd1);
    chk("midfetch_rst_done", {191'b0, SWAP_DONE_O}, 192'd0);
    // Request held across release: accepted on the first edge after it.
    @(negedge CLK_I);
    ROW_REQ_I  = 1'b1;
    ROW_ADDR_I = 4'd2;
    exp_q.push_back(model_row(2));
    #2 RST_N_I = 1'b1;
    @(posedge CLK_I);
    #1;
    ROW_REQ_I = 1'b0;
    wait_row(-1, e);
    ack_row(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
